// File: rtl/wisc_pkg.sv
// Shared definitions for the flag/branch unit: ALU opcodes, branch
// condition codes, flag bit positions and the per-opcode flag write mask.
package wisc_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_RED    = 3'b011;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;
    localparam logic [2:0] OP_PADSUB = 3'b111;

    // Branch condition codes
    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Flag bit positions inside flags_t
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [2:0] flags_t;

    // Which flag bits an ALU opcode is allowed to update.
    function automatic flags_t flag_wmask(input logic [2:0] opcode);
        flags_t mask;
        case (opcode)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default:                        mask = 3'b000;  // RED, PADSUB
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Branch request handshake between decode (master) and the flag/branch
// unit (slave). A request is accepted when br_valid & br_ready.
interface flag_branch_unit_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic        br_is_reg;
    logic [15:0] br_pc_plus2;
    logic [8:0]  br_imm9;
    logic [15:0] br_reg;

    modport master (
        output br_valid, br_cond, br_is_reg, br_pc_plus2, br_imm9, br_reg,
        input  br_ready
    );

    modport slave (
        input  br_valid, br_cond, br_is_reg, br_pc_plus2, br_imm9, br_reg,
        output br_ready
    );
endinterface

// File: rtl/flag_branch_unit_cond.sv
// Combinational branch condition evaluator: decides taken/not-taken for
// a 3-bit condition code against a set of {Z,V,N} flags.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] cond,
    input  flags_t     flags,
    output logic       taken
);

    logic z, v, n;
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // Condition decode
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = !z;
            COND_EQ:     taken = z;
            COND_GT:     taken = !z && !n;
            COND_LT:     taken = n;
            COND_GTE:    taken = z || !n;
            COND_LTE:    taken = n || z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag/branch unit: holds the architectural Z/V/N flags written by the
// EX-stage ALU, resolves branches against them and issues a one-cycle
// redirect followed by a counted flush.
// Optional feature: define FLAG_BYPASS_EN to forward a same-cycle EX flag
// write into branch evaluation instead of stalling the branch one cycle.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int     FLUSH_CYCLES = 2,
    parameter flags_t RESET_FLAGS  = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic [2:0]                ex_opcode,
    input  flags_t                    ex_flags,
    input  logic                      stall,
    flag_branch_unit_if.slave         br,
    output logic                      redirect_valid,
    output logic [15:0]               redirect_pc,
    output logic                      flush,
    output flags_t                    flags_q
);

    flags_t      wmask;
    flags_t      eff_flags;
    logic        hazard;
    logic        taken;
    logic        fire;
    logic [15:0] target;
    logic [2:0]  flush_cnt;

    assign wmask = ex_valid ? flag_wmask(ex_opcode) : 3'b000;

`ifdef FLAG_BYPASS_EN
    // Merge the in-flight EX flag write so the branch sees it this cycle.
    assign hazard    = 1'b0;
    assign eff_flags = (ex_flags & wmask) | (flags_q & ~wmask);
`else
    // Hold the branch off for one cycle while EX is writing flags.
    assign hazard    = (wmask != 3'b000);
    assign eff_flags = flags_q;
`endif

    branch_cond_eval u_cond (
        .cond  (br.br_cond),
        .flags (eff_flags),
        .taken (taken)
    );

    assign br.br_ready = !stall && (flush_cnt == 3'd0) && !hazard;
    assign fire        = br.br_valid && br.br_ready;

    // Sign-extended word offset, shifted to a byte offset; wraps at 16 bits.
    assign target = br.br_is_reg ? br.br_reg
                                 : br.br_pc_plus2 + {{6{br.br_imm9[8]}}, br.br_imm9, 1'b0};

    assign flush = (flush_cnt != 3'd0) || redirect_valid;

    // Architectural flag register, updated bitwise under the opcode mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= RESET_FLAGS;
        end else if (!stall) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            flags_q <= (ex_flags & wmask) | (flags_q & ~wmask);
        end
    end

    // Redirect pulse, target register and flush counter. The counter holds
    // during the redirect cycle so flush covers redirect + FLUSH_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 16'h0000;
            flush_cnt      <= 3'd0;
        end else begin
            redirect_valid <= fire && taken;
            if (fire && taken) begin
                redirect_pc <= target;
                flush_cnt   <= 3'(FLUSH_CYCLES);
            end else if (!redirect_valid && flush_cnt != 3'd0) begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

endmodule
